dice_roller: RTL and testbench
==============================

# dice_roller

Two-player dice source that drives the display/scoring logic. It takes raw push-buttons from the board, synchronises and debounces them, and spins a per-player die face while the button is held. On release it latches the face and emits a one-cycle `rolledN` pulse. Each player gets one roll per round; a round closes once both players have rolled, and both players are then re-armed.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced level changes (board build overrides, e.g. 250000).
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width (derived; do not override).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn1`  in  1  player 1 button, raw, asynchronous, active-high.
- `btn2`  in  1  player 2 button, raw, asynchronous, active-high.
- `dice1`  out  3  player 1 latched face, 1..6.
- `dice2`  out  3  player 2 latched face, 1..6.
- `rolled1`  out  1  one-cycle pulse; `dice1` is valid in the same cycle.
- `rolled2`  out  1  one-cycle pulse; `dice2` is valid in the same cycle.
- `ready1`  out  1  player 1 may roll (channel in IDLE).
- `ready2`  out  1  player 2 may roll (channel in IDLE).

## Operation
- Synchroniser: each button passes through a 2-FF synchroniser. Nothing downstream sees the raw input.
- Debounce: the debounced level changes only after the synced level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle clears the counter.
- Face counter:
  - One per player, 3-bit, resets to 1.
  - Advances by 1 each cycle in ROLLING; 6 wraps to 1.
  - Holds in every other state and persists across rounds.
  - Values 0 and 7 are unreachable. If seen, the counter is forced to 1.
- Per-player FSM:
  - IDLE: on debounced rising edge, go to ROLLING.
  - ROLLING: on debounced falling edge, `diceN` <= counter (value before this cycle's advance), `rolledN` = 1 for this cycle, and go to LOCKED.
  - LOCKED: button ignored; wait for round end.
- Round end:
  - When both FSMs are in LOCKED, both go to IDLE on the next cycle.
  - A button already held when a channel re-enters IDLE does not start a roll. A fresh debounced rising edge is required.
- `diceN` changes only in the `rolledN` cycle. It is stable at all other times, including during ROLLING.
- `readyN` = (stateN == IDLE), registered.
- Reset values: `dice1` = `dice2` = 1, `rolled1` = `rolled2` = 0, `ready1` = `ready2` = 1, FSMs in IDLE, debounced levels 0, counters 1.

## Timing
- Press to ROLLING: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after `btn` rises.
- Release to `rolledN` pulse: 2 + `DEBOUNCE_CYCLES` + 1 cycles after `btn` falls.
- `rolledN` is exactly one cycle wide and never back-to-back for the same player.
- Last player's `rolledN` cycle = T: both channels are LOCKED at T+1, and `ready1` = `ready2` = 1 at T+2.
- Simultaneous releases: both pulses fire in the same cycle, and both channels re-arm together.
- Reset mid-ROLLING or mid-LOCKED: immediate return to reset values, with no pulse emitted.
- Consumer contract: the consumer registers `rolledN` and samples `diceN` at any later cycle. Values hold until that player's next pulse, which comes at the earliest in the next round.

## Structure
- Package `dice_pkg` holds:
  - `FACE_MIN` = 3'd1 and `FACE_MAX` = 3'd6;
  - the channel state typedef {IDLE, ROLLING, LOCKED};
  - the default for `DEBOUNCE_CYCLES`.
- Sub-module `dice_channel` contains the synchroniser, debounce, FSM, face counter and dice/rolled/ready registers for one player. It takes input `round_end` and output `locked`, and is instantiated twice.
- The top level generates `round_end` = `locked1` & `locked2`, registered.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset: check `dice1` = `dice2` = 1, rolled = 0, ready = 1. Then assert reset again mid-ROLLING: no pulse, `ready1` = 1, counter = 1.
- Face wrap: from counter = 1, hold `btn1` so the counter advances 7 times. Required: a single `rolled1` pulse with `dice1` = 2, `ready1` = 0, and `dice1` unchanged during the hold.
- Glitch rejection: 3-cycle `btn2` pulses separated by 3 low cycles. Required: no state change, `rolled2` never asserts, `ready2` stays 1.
- One roll per round: player 1 rolls twice before player 2 rolls once. Required: exactly one `rolled1` pulse, and `dice1` holds its first value. After player 2 rolls, both ready = 1 two cycles later.
- Simultaneous release: both buttons released in the same cycle. Required: `rolled1` and `rolled2` pulse together, and both ready = 1 two cycles later.
- Held through re-arm: `btn1` held across round end. Required: no roll until it is released and pressed again.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared constants, channel state encoding and face-advance helper for the dice roller.
package dice_pkg;

    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        LOCKED
    } chan_state_e;

    function automatic logic face_legal(input logic [2:0] f);
        return (f >= FACE_MIN) && (f <= FACE_MAX);
    endfunction

    // Illegal encodings fall back to FACE_MIN as well, so the counter self-heals.
    function automatic logic [2:0] next_face(input logic [2:0] f);
        if (!face_legal(f) || (f == FACE_MAX)) begin
            return FACE_MIN;
        end
        return f + 3'd1;
    endfunction

endpackage

// File: rtl/dice_channel.sv
// One player's path: button synchroniser, debounce, roll FSM, spinning face and latched result.
module dice_channel
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       round_end,
    output logic [2:0] dice,
    output logic       rolled,
    output logic       ready,
    output logic       locked
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic             rise;
    logic             fall;
    chan_state_e      state_q;
    chan_state_e      state_d;
    logic [2:0]       face_q;
    logic [2:0]       face_d;
    logic [2:0]       dice_q;
    logic [2:0]       dice_d;
    logic             rolled_q;
    logic             rolled_d;
    logic             ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // The level only flips after DEBOUNCE_CYCLES back-to-back mismatching cycles.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

    always_comb begin
        state_d  = state_q;
        dice_d   = dice_q;
        rolled_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ROLLING;
                end
            end
            ROLLING: begin
                if (fall) begin
                    state_d  = LOCKED;
                    dice_d   = face_legal(face_q) ? face_q : FACE_MIN;
                    rolled_d = 1'b1;
                end
            end
            LOCKED: begin
                if (round_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The face spins only while rolling and keeps its value across rounds.
    always_comb begin
        face_d = face_q;
        if (!face_legal(face_q)) begin
            face_d = FACE_MIN;
        end else if (state_q == ROLLING) begin
            face_d = next_face(face_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            face_q   <= FACE_MIN;
            dice_q   <= FACE_MIN;
            rolled_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            face_q   <= face_d;
            dice_q   <= dice_d;
            rolled_q <= rolled_d;
            ready_q  <= (state_d == IDLE);
        end
    end

    assign dice   = dice_q;
    assign rolled = rolled_q;
    assign ready  = ready_q;
    assign locked = (state_q == LOCKED);

endmodule

// File: rtl/dice_roller.sv
// Two-player dice source: two independent channels re-armed together once both have rolled.
module dice_roller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    input  logic       btn2,
    output logic [2:0] dice1,
    output logic [2:0] dice2,
    output logic       rolled1,
    output logic       rolled2,
    output logic       ready1,
    output logic       ready2
);

    logic locked1;
    logic locked2;
    logic round_end_q;

    dice_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn1),
        .round_end(round_end_q),
        .dice     (dice1),
        .rolled   (rolled1),
        .ready    (ready1),
        .locked   (locked1)
    );

    dice_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn2),
        .round_end(round_end_q),
        .dice     (dice2),
        .rolled   (rolled2),
        .ready    (ready2),
        .locked   (locked2)
    );

    // Registered so both channels leave LOCKED on the same edge, one cycle after the last lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_end_q <= 1'b0;
        end else begin
            round_end_q <= locked1 & locked2;
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: expected faces are queued at stimulus time and popped on each rolled pulse.
module tb_dice_roller;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn1;
    logic       btn2;
    logic [2:0] dice1;
    logic [2:0] dice2;
    logic       rolled1;
    logic       rolled2;
    logic       ready1;
    logic       ready2;

    int         checks = 0;
    int         failures = 0;
    logic [2:0] expQ1[$];
    logic [2:0] expQ2[$];
    logic [2:0] last1 = 3'd1;
    logic [2:0] last2 = 3'd1;
    logic       prev1 = 1'b0;
    logic       prev2 = 1'b0;
    int         pulses1 = 0;
    int         pulses2 = 0;
    int         faceModel1;
    int         faceModel2;

    dice_roller #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn1   (btn1),
        .btn2   (btn2),
        .dice1  (dice1),
        .dice2  (dice2),
        .rolled1(rolled1),
        .rolled2(rolled2),
        .ready1 (ready1),
        .ready2 (ready2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int player, input logic level);
        if (player == 1) btn1 = level;
        else             btn2 = level;
    endtask

    function automatic int adv(input int f, input int n);
        return ((f - 1 + n) % 6) + 1;
    endfunction

    // Press for `hold` cycles; the latched face is the counter after hold-1 advances.
    task automatic roll(input int player, input int hold);
        if (player == 1) begin
            expQ1.push_back(3'(adv(faceModel1, hold - 1)));
            faceModel1 = adv(faceModel1, hold);
        end else begin
            expQ2.push_back(3'(adv(faceModel2, hold - 1)));
            faceModel2 = adv(faceModel2, hold);
        end
        applyStimulus(player, 1'b1);
        tick(hold);
        applyStimulus(player, 1'b0);
    endtask

    task automatic waitPulse(input int player, input string tag);
        logic seen;
        int   n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < LAT + 4) begin
            tick(1);
            n++;
            seen = (player == 1) ? rolled1 : rolled2;
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, n, LAT);
    endtask

    // Scoreboard side: every pulse pops an expected face; between pulses the face must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last1 = 3'd1;
            last2 = 3'd1;
            prev1 = 1'b0;
            prev2 = 1'b0;
        end else begin
            if (rolled1) begin
                pulses1++;
                checkOutput("rolled1_back_to_back", 32'(prev1), 32'd0);
                checkOutput("rolled1_expected", 32'(expQ1.size() != 0), 32'd1);
                if (expQ1.size() != 0) last1 = expQ1.pop_front();
                checkOutput("dice1_at_pulse", 32'(dice1), 32'(last1));
            end else begin
                checkOutput("dice1_stable", 32'(dice1), 32'(last1));
            end
            if (rolled2) begin
                pulses2++;
                checkOutput("rolled2_back_to_back", 32'(prev2), 32'd0);
                checkOutput("rolled2_expected", 32'(expQ2.size() != 0), 32'd1);
                if (expQ2.size() != 0) last2 = expQ2.pop_front();
                checkOutput("dice2_at_pulse", 32'(dice2), 32'(last2));
            end else begin
                checkOutput("dice2_stable", 32'(dice2), 32'(last2));
            end
            prev1 = rolled1;
            prev2 = rolled2;
        end
    end

    initial begin
        rst_n = 1'b0;
        btn1 = 1'b0;
        btn2 = 1'b0;
        faceModel1 = 1;
        faceModel2 = 1;
        tick(3);
        checkOutput("reset_dice1", 32'(dice1), 32'd1);
        checkOutput("reset_dice2", 32'(dice2), 32'd1);
        checkOutput("reset_rolled1", 32'(rolled1), 32'd0);
        checkOutput("reset_rolled2", 32'(rolled2), 32'd0);
        checkOutput("reset_ready1", 32'(ready1), 32'd1);
        checkOutput("reset_ready2", 32'(ready2), 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Reset in the middle of a roll must abandon it silently.
        applyStimulus(1, 1'b1);
        tick(LAT + 3);
        checkOutput("ready1_while_rolling", 32'(ready1), 32'd0);
        rst_n = 1'b0;
        applyStimulus(1, 1'b0);
        #1;
        checkOutput("midroll_reset_ready1", 32'(ready1), 32'd1);
        checkOutput("midroll_reset_rolled1", 32'(rolled1), 32'd0);
        checkOutput("midroll_reset_dice1", 32'(dice1), 32'd1);
        tick(2);
        rst_n = 1'b1;
        faceModel1 = 1;
        tick(LAT + 3);
        checkOutput("midroll_no_pulse", pulses1, 0);

        // Seven advances from 1 wrap through 6 and land on 2.
        roll(1, 8);
        waitPulse(1, "wrap_pulse1");
        checkOutput("wrap_dice1", 32'(dice1), 32'd2);
        tick(1);
        checkOutput("wrap_ready1", 32'(ready1), 32'd0);

        repeat (3) begin
            applyStimulus(2, 1'b1);
            tick(3);
            applyStimulus(2, 1'b0);
            tick(3);
        end
        tick(LAT);
        checkOutput("glitch_ready2", 32'(ready2), 32'd1);
        checkOutput("glitch_no_pulse2", pulses2, 0);

        // Player 1 is locked: a second press must be ignored.
        applyStimulus(1, 1'b1);
        tick(6);
        applyStimulus(1, 1'b0);
        tick(LAT + 3);
        checkOutput("second_roll_pulses1", pulses1, 1);
        checkOutput("second_roll_dice1", 32'(dice1), 32'd2);
        roll(2, 5);
        waitPulse(2, "round1_pulse2");
        tick(1);
        checkOutput("round1_t1_ready1", 32'(ready1), 32'd0);
        checkOutput("round1_t1_ready2", 32'(ready2), 32'd0);
        tick(1);
        checkOutput("round1_t2_ready1", 32'(ready1), 32'd1);
        checkOutput("round1_t2_ready2", 32'(ready2), 32'd1);

        expQ1.push_back(3'(adv(faceModel1, 9)));
        expQ2.push_back(3'(adv(faceModel2, 9)));
        faceModel1 = adv(faceModel1, 10);
        faceModel2 = adv(faceModel2, 10);
        applyStimulus(1, 1'b1);
        applyStimulus(2, 1'b1);
        tick(10);
        applyStimulus(1, 1'b0);
        applyStimulus(2, 1'b0);
        waitPulse(1, "sim_pulse1");
        checkOutput("sim_rolled2_together", 32'(rolled2), 32'd1);
        tick(2);
        checkOutput("sim_ready1", 32'(ready1), 32'd1);
        checkOutput("sim_ready2", 32'(ready2), 32'd1);

        // Button 1 is pressed again while locked and stays held through the re-arm.
        roll(1, 6);
        waitPulse(1, "held_pulse1");
        applyStimulus(1, 1'b1);
        tick(LAT + 3);
        roll(2, 6);
        waitPulse(2, "held_pulse2");
        tick(2);
        checkOutput("held_rearm_ready1", 32'(ready1), 32'd1);
        checkOutput("held_rearm_ready2", 32'(ready2), 32'd1);
        tick(LAT + 3);
        checkOutput("held_no_roll_ready1", 32'(ready1), 32'd1);
        applyStimulus(1, 1'b0);
        tick(LAT + 3);
        checkOutput("held_release_ready1", 32'(ready1), 32'd1);
        checkOutput("held_release_pulses1", pulses1, 3);
        roll(1, 7);
        waitPulse(1, "fresh_pulse1");
        tick(1);
        checkOutput("fresh_ready1", 32'(ready1), 32'd0);

        tick(3);
        checkOutput("total_pulses1", pulses1, 4);
        checkOutput("total_pulses2", pulses2, 3);
        checkOutput("expQ1_drained", expQ1.size(), 0);
        checkOutput("expQ2_drained", expQ2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
